// File: rtl/interleaver_pkg.sv
// interleaver_pkg: shared types, state encoding and arithmetic helpers for the interleaver datapath
//   acc_t    signed accumulator/data word
//   state_t  ACCUM (taking edge beats) / DRAIN (emitting neuron sums)
//   cnt_w    counter width for n states, never less than 1 bit
//   sat_add  signed add clamped to the acc_t range
package interleaver_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] acc_t;

    typedef enum logic {ACCUM, DRAIN} state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The extra sum bit disagreeing with the sign bit means overflow; its value picks the rail.
    function automatic acc_t sat_add(input acc_t a, input acc_t b);
        logic signed [DATA_W:0] s;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        return (s[DATA_W] != s[DATA_W-1]) ?
            (s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}}) :
            s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/lane_collision_detect.sv
// lane_collision_detect: priority mask so only the lowest lane targeting a neuron is applied
//   index      per-lane target neuron
//   lane_en    1 where no lower-numbered lane shares this lane's index
//   collision  1 when any lane was masked
module lane_collision_detect #(
    parameter int z     = 8,
    parameter int log_p = 6
) (
    input  logic [z-1:0][log_p-1:0] index,
    output logic [z-1:0]            lane_en,
    output logic                    collision
);

    always_comb begin
        lane_en = '1;
        for (int k = 1; k < z; k++)
            for (int j = 0; j < k; j++)
                if (index[j] == index[k]) lane_en[k] = 1'b0;
        collision = ~&lane_en;
    end

endmodule

// File: rtl/deinterleaver_accumulator.sv
// deinterleaver_accumulator: scatter-accumulates z edge values per beat into p neuron sums, then drains them
//   clk, reset               clock, synchronous active-high reset
//   in_valid/in_ready        edge beat handshake (accepted only while accumulating)
//   in_data, in_index        per-lane signed contribution and target neuron
//   out_valid/out_ready      drain beat handshake
//   out_data, out_beat       sums of neurons out_beat*z+k and the beat number
//   sweep_done               pulse after the last drain beat handshakes
//   collision_err            sticky flag: duplicate index inside one accepted beat
module deinterleaver_accumulator
    import interleaver_pkg::*;
#(
    parameter int p  = 64,
    parameter int fo = 8,
    parameter int z  = 8,
    parameter int W  = DATA_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [z-1:0][W-1:0]              in_data,
    input  logic [z-1:0][$clog2(p)-1:0]      in_index,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [z-1:0][W-1:0]              out_data,
    output logic [cnt_w(p/z)-1:0]            out_beat,
    output logic                             sweep_done,
    output logic                             collision_err
);

    localparam int NCYC  = p * fo / z;
    localparam int NBEAT = p / z;
    localparam int log_p = $clog2(p);
    localparam int CW    = cnt_w(NCYC);
    localparam int BW    = cnt_w(NBEAT);

    state_t             state, state_nxt;
    logic [CW-1:0]      cyc;
    logic [BW-1:0]      beat;
    logic [log_p-1:0]   base;
    logic [z-1:0]       lane_en;
    logic               collision;
    logic               in_fire, out_fire, last_cyc, last_beat;
    acc_t               acc     [p];
    acc_t               acc_nxt [p];

    lane_collision_detect #(.z(z), .log_p(log_p)) u_lcd (
        .index     (in_index),
        .lane_en   (lane_en),
        .collision (collision)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_cyc  = (cyc == CW'(NCYC - 1));
    assign last_beat = (beat == BW'(NBEAT - 1));
    assign base      = log_p'(int'(beat) * z);
    assign out_beat  = beat;

    always_comb begin
        state_nxt = state;
        if (in_fire && last_cyc) state_nxt = DRAIN;
        if (out_fire && last_beat) state_nxt = ACCUM;
    end

    // Enabled lanes carry distinct indices, so each neuron sees at most one saturating add per beat.
    always_comb begin
        acc_nxt = acc;
        if (in_fire)
            for (int k = 0; k < z; k++)
                if (lane_en[k]) acc_nxt[in_index[k]] = sat_add(acc_nxt[in_index[k]], acc_t'(in_data[k]));
        if (out_fire)
            for (int k = 0; k < z; k++)
                acc_nxt[base + log_p'(k)] = '0;
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < z; k++)
            out_data[k] = out_valid ? W'(acc[base + log_p'(k)]) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ACCUM;
            cyc           <= '0;
            beat          <= '0;
            sweep_done    <= 1'b0;
            collision_err <= 1'b0;
            acc           <= '{default: '0};
        end else begin
            state         <= state_nxt;
            acc           <= acc_nxt;
            sweep_done    <= out_fire && last_beat;
            collision_err <= collision_err || (in_fire && collision);
            if (in_fire) cyc <= last_cyc ? '0 : cyc + 1'b1;
            if (out_fire) beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

endmodule

// File: tb/tb_deinterleaver_accumulator.sv
// tb_deinterleaver_accumulator: directed sweeps with a queue scoreboard checked by an independent drain monitor
module tb_deinterleaver_accumulator;

    localparam int P = 64, Z = 8, W = 16, LP = 6, NB = 8, NC = 64;

    logic                 clk = 0, reset = 1, in_valid = 0, out_ready = 1;
    logic                 in_ready, out_valid, sweep_done, collision_err;
    logic [Z-1:0][W-1:0]  in_data = '0, out_data;
    logic [Z-1:0][LP-1:0] in_index = '0;
    logic [2:0]           out_beat;

    typedef struct {
        logic [Z-1:0][W-1:0] data;
        logic [2:0]          beat;
    } beat_t;

    beat_t sb[$];
    int    total = 0, passed = 0;

    always #5 clk = ~clk;

    deinterleaver_accumulator #(.p(P), .fo(8), .z(Z), .W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_index      (in_index),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_beat      (out_beat),
        .sweep_done    (sweep_done),
        .collision_err (collision_err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Address pattern 8k+3c: distinct within a beat, and every lane visits every neuron once per sweep.
    function automatic void beat_vec(input int mode, input int c,
                                     output logic [Z-1:0][W-1:0] d, output logic [Z-1:0][LP-1:0] ix);
        for (int k = 0; k < Z; k++) begin
            ix[k] = LP'((8 * k + 3 * c) % P);
            d[k]  = (mode == 1) ? W'(k + 1) : (mode == 2) ? W'(0) : W'(1);
        end
        if (mode == 2 && c < 3) begin
            ix[0] = 6'd5;
            d[0]  = (c == 2) ? 16'sd1 : 16'sd32767;
        end
        if (mode == 2 && c < 2) begin
            ix[1] = 6'd9;
            d[1]  = (c == 0) ? 16'h8000 : 16'hFFFF;
        end
        if (mode == 3 && c == 0) begin
            ix[0] = 6'd10;
            d[0]  = 16'd5;
            ix[3] = 6'd10;
            d[3]  = 16'd7;
        end
    endfunction

    // Hand-derived neuron sums for each sweep kind.
    function automatic int exp_sum(input int mode, input int n);
        case (mode)
            0:       return 8;
            1:       return 36;
            2:       return (n == 5) ? 32767 : (n == 9) ? -32768 : 0;
            default: return (n == 10) ? 13 : (n == 0 || n == 24) ? 7 : 8;
        endcase
    endfunction

    task automatic push_expected(input int mode);
        beat_t e;
        for (int b = 0; b < NB; b++) begin
            e.beat = 3'(b);
            for (int k = 0; k < Z; k++) e.data[k] = W'(exp_sum(mode, b * Z + k));
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [Z-1:0][W-1:0] d, input logic [Z-1:0][LP-1:0] ix);
        int n = 0;
        in_data  = d;
        in_index = ix;
        in_valid = 1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic wait_drain(input bit stall);
        int n = 0;
        check("drain_latency", out_valid, 1);
        if (stall) begin
            out_ready = 0;
            in_valid  = 1;
            for (int k = 0; k < Z; k++) begin
                in_data[k]  = 16'd100;
                in_index[k] = LP'(k);
            end
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            out_ready = 1;
            @(negedge clk);
            @(negedge clk);
            check("stall_beat", out_beat, 2);
            out_ready = 0;
            repeat (3) @(negedge clk);
            check("stall_in_ready2", in_ready, 0);
            out_ready = 1;
        end else begin
            in_valid = 0;
        end
        while (!sweep_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sweep_done", sweep_done, 1);
        in_valid = 0;
        @(negedge clk);
        check("sweep_done_pulse", sweep_done, 0);
    endtask

    task automatic run_sweep(input int mode, input bit gaps, input bit stall, input int nbeats);
        logic [Z-1:0][W-1:0]  d;
        logic [Z-1:0][LP-1:0] ix;
        for (int c = 0; c < nbeats; c++) begin
            beat_vec(mode, c, d, ix);
            if (gaps && $urandom_range(1) == 1) begin
                in_valid = 0;
                @(negedge clk);
            end
            if (mode == 3 && c == 0) check("collision_pre", collision_err, 0);
            if (c == NC - 1) push_expected(mode);
            send(d, ix);
            if (mode == 3 && c == 0) check("collision_set", collision_err, 1);
        end
        if (nbeats == NC) wait_drain(stall);
        else in_valid = 0;
    endtask

    task automatic reset_checks();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_beat", out_beat, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_collision_err", collision_err, 0);
    endtask

    // Monitor: pops an expectation on every drain handshake and checks outputs hold while stalled.
    always @(negedge clk) begin : monitor
        beat_t               e;
        logic                held;
        logic [2:0]          hb;
        logic [Z-1:0][W-1:0] hd;
        if (reset) begin
            held = 0;
        end else begin
            if (held && out_valid) begin
                check("stall_hold_beat", out_beat, hb);
                check("stall_hold_data", out_data, hd);
            end
            held = out_valid && !out_ready;
            hb   = out_beat;
            hd   = out_data;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("drain_data", out_data, e.data);
                    check("drain_beat", out_beat, e.beat);
                    check("drain_in_ready", in_ready, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        reset_checks();
        reset = 0;
        @(negedge clk);
        run_sweep(0, 0, 0, NC);
        check("no_collision", collision_err, 0);
        run_sweep(1, 0, 0, NC);
        run_sweep(2, 0, 0, NC);
        run_sweep(1, 1, 1, NC);
        run_sweep(3, 0, 0, NC);
        check("collision_sticky", collision_err, 1);
        run_sweep(1, 0, 0, 20);
        reset = 1;
        @(negedge clk);
        reset_checks();
        reset = 0;
        @(negedge clk);
        run_sweep(1, 0, 0, NC);
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
